barrel_rot_pipe: RTL and testbench
==================================

Name: barrel_rot_pipe

Overview:
- Parametrised, pipelined barrel shifter/rotator; the next generation after the fixed 8-bit right rotater.
- Supports four modes: rotate right, rotate left, logical shift right, arithmetic shift right.
- Uses log2(WIDTH) mux stages with one register slot per stage.
- Has valid/ready handshake on both sides with per-stage bubble collapse. Sits in the datapath between operand source and ALU result bus.

Parameters:
- WIDTH, 8, data width; power of two, >= 4.
- SHW, $clog2(WIDTH), shift-amount width and stage count (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  SHW  shift/rotate amount, 0..WIDTH-1.
- in_mode  in  2  00 ROR, 01 ROL, 10 LSR, 11 ASR.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  result.

Behaviour:
- One clock (clk). Reset is synchronous, active-low (rst_n sampled on rising clk).
- Reset clears all stage valid bits, data, amount and mode registers to 0. Therefore out_valid=0 and out_data=0 after reset.
- in_ready during reset is don't-care.
- Stage k (k=0..SHW-1) processes bit k of the amount, shifting by 2^k.
  - ROR: d[i] <= d[(i+2^k) mod WIDTH].
  - ROL: d[i] <= d[(i-2^k) mod WIDTH].
  - LSR: d[i] <= d[i+2^k], or 0 when the index >= WIDTH.
  - ASR: as LSR, but fills with the original MSB (sign). The sign is captured at input and carried down the pipe.
  - Amount bit k = 0: stage passes data unchanged.
- Each stage registers its result together with the remaining amount bits, the mode, the sign and a valid bit.
- out_data and out_valid come directly from the last stage register.
- Latency is SHW cycles from accept (in_valid & in_ready) to out_valid, with no stalls. WIDTH=8 gives 3 cycles.
- Throughput is 1 beat/cycle.
- Stall rules:
  - Stage k loads when its slot is empty or its slot's content moves on this cycle. "Moves" means the next stage loads it, or for the last stage, out_ready=1.
  - in_ready = stage-0 load condition. It is combinational from out_ready through the chain and has no combinational path from in_valid.
  - A slot whose load condition is false holds all fields.
  - Bubbles collapse: an empty stage loads even when downstream is stalled.
- Valid rules:
  - out_valid, once asserted, stays high with out_data stable until out_ready=1.
  - Beats never reorder, drop or duplicate.
- Amount 0 in any mode gives out_data = in_data.
- Modes:
  - ROL and ROR with amounts a and WIDTH-a give equal results.
  - LSR/ASR with the amount at maximum (WIDTH-1) leaves 1 data bit or sign fill.
- If the reset edge arrives mid-operation, all in-flight beats are discarded. No output is produced for them.
- Simultaneous accept and emit in the same cycle with a full pipe is legal, and throughput is maintained.

Decomposition:
- Package barrel_pkg holds:
  - Mode localparams MODE_ROR=2'b00, MODE_ROL=2'b01, MODE_LSR=2'b10, MODE_ASR=2'b11.
  - A helper function for the fill bit.
- Sub-module barrel_stage (parameters WIDTH, DIST):
  - Combinational direction/fill mux for one 2^k distance.
  - Register slot with valid bit and load-enable logic.
- Top instantiates SHW stages in a generate loop.

Test Plan:
- WIDTH=8, in_data=8'hB1, amt=3, ROR -> out_data=8'h36 after 3 cycles, out_valid for one cycle with out_ready=1.
- Same operand and amt=3 in ROL -> 8'h8D. In LSR -> 8'h16. In ASR -> 8'hF6. Back-to-back beats return in order on consecutive cycles.
- amt=0 in all four modes with in_data=8'h5A -> 8'h5A each time.
- Fill pipe, hold out_ready=0 for 5 cycles:
  - out_data stays stable.
  - in_ready drops after 3 accepted beats (slots full).
  - Release gives 3 results in order, then in_ready=1.
- Insert a bubble (in_valid=0 for 1 cycle) while out_ready=0 -> the bubble collapses, and the pipe accepts one more beat than without collapse.
- Assert rst_n=0 for 1 cycle with 2 beats in flight -> out_valid=0 and out_data=0 the next cycle. No stale result is ever emitted. A beat issued afterwards returns a correct result.

Source files
------------

// File: rtl/barrel_pkg.sv
// barrel_pkg: shared definitions for the pipelined barrel shifter/rotator.
//   MODE_* : encodings of the 2-bit operation mode.
//   fill_bit() : bit shifted in at the top for the logical/arithmetic right shifts.
package barrel_pkg;

  localparam logic [1:0] MODE_ROR = 2'b00;
  localparam logic [1:0] MODE_ROL = 2'b01;
  localparam logic [1:0] MODE_LSR = 2'b10;
  localparam logic [1:0] MODE_ASR = 2'b11;

  // ASR replicates the operand's original sign; LSR fills with zeros.
  function automatic logic fill_bit(input logic [1:0] mode, input logic sign);
    return (mode == MODE_ASR) ? sign : 1'b0;
  endfunction

endpackage

// File: rtl/barrel_stage.sv
// barrel_stage: one pipeline slot of the barrel shifter, handling one power-of-two distance.
//   clk, rst_n              : clock, synchronous active-low reset
//   up_valid/data/amt/mode/sign : beat offered by the previous slot (or the block input)
//   down_load               : the consumer of this slot takes its content this cycle
//   load                    : this slot captures the upstream beat this cycle
//   valid/data/amt/mode/sign : registered slot contents
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIST  = 1,
  localparam int unsigned SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic [SHW-1:0]   up_amt,
  input  logic [1:0]       up_mode,
  input  logic             up_sign,
  input  logic             down_load,
  output logic             load,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [SHW-1:0]   amt,
  output logic [1:0]       mode,
  output logic             sign
);

  // Amount bit that selects this slot's distance.
  localparam int unsigned AmtBit = $clog2(DIST);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [SHW-1:0]   amt_q;
  logic [1:0]       mode_q;
  logic             sign_q;

  logic             fill;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] data_d;

  assign fill = fill_bit(up_mode, up_sign);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    localparam int unsigned RorSrc  = (i + DIST) % WIDTH;
    localparam int unsigned RolSrc  = (i + WIDTH - DIST) % WIDTH;
    localparam bit          InRange = (i + DIST) < WIDTH;
    // Right shifts share the rotate-right source; off the top end they take the fill bit.
    assign shifted[i] = (up_mode == MODE_ROR) ? up_data[RorSrc] :
                        (up_mode == MODE_ROL) ? up_data[RolSrc] :
                        InRange               ? up_data[RorSrc] : fill;
  end

  assign data_d = up_amt[AmtBit] ? shifted : up_data;

  // An empty slot always loads, so bubbles collapse even while downstream is stalled.
  assign load = !valid_q || down_load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= '0;
      sign_q  <= 1'b0;
    end else if (load) begin
      valid_q <= up_valid;
      data_q  <= data_d;
      amt_q   <= up_amt;
      mode_q  <= up_mode;
      sign_q  <= up_sign;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign amt   = amt_q;
  assign mode  = mode_q;
  assign sign  = sign_q;

endmodule

// File: rtl/barrel_rot_pipe.sv
// barrel_rot_pipe: pipelined barrel rotator/shifter (ROR, ROL, LSR, ASR), one slot per
// amount bit, valid/ready on both sides, SHW-cycle latency, one beat per cycle.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake
//   in_data/amt/mode    : operand, amount (0..WIDTH-1), mode (00 ROR, 01 ROL, 10 LSR, 11 ASR)
//   out_valid/out_ready : output handshake
//   out_data            : result
module barrel_rot_pipe
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Index k is the input of stage k; index SHW is the last slot's output.
  logic [SHW:0]     v;
  logic [SHW:0]     s;
  logic [WIDTH-1:0] d [SHW+1];
  logic [SHW-1:0]   a [SHW+1];
  logic [1:0]       m [SHW+1];
  logic [SHW-1:0]   ld;
  logic [SHW-1:0]   dn;

  assign v[0] = in_valid;
  assign d[0] = in_data;
  assign a[0] = in_amt;
  assign m[0] = in_mode;
  assign s[0] = in_data[WIDTH-1];

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    if (k == SHW - 1) begin : g_last
      assign dn[k] = out_ready;
    end else begin : g_mid
      assign dn[k] = ld[k+1];
    end

    barrel_stage #(
      .WIDTH(WIDTH),
      .DIST (1 << k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (v[k]),
      .up_data  (d[k]),
      .up_amt   (a[k]),
      .up_mode  (m[k]),
      .up_sign  (s[k]),
      .down_load(dn[k]),
      .load     (ld[k]),
      .valid    (v[k+1]),
      .data     (d[k+1]),
      .amt      (a[k+1]),
      .mode     (m[k+1]),
      .sign     (s[k+1])
    );
  end

  // Ready ripples back from out_ready through the load chain; never depends on in_valid.
  assign in_ready  = ld[0];
  assign out_valid = v[SHW];
  assign out_data  = d[SHW];

  // Control fields are not needed once the last slot has applied its distance.
  logic unused_tail;
  assign unused_tail = ^{a[SHW], m[SHW], s[SHW]};

endmodule

// File: tb/tb_barrel_rot_pipe.sv
module tb_barrel_rot_pipe;

  localparam int W  = 8;
  localparam int SW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_amt = '0;
  logic [1:0]    in_mode = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;

  always #5 clk = ~clk;

  barrel_rot_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  typedef struct {
    logic [W-1:0] exp;
    int           acc;
    bit           lat;
  } item_t;

  item_t        q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           ov_cnt = 0;
  int           pop_cnt = 0;
  int           accs = 0;
  bit           acc_now = 1'b0;
  logic [W-1:0] drv_exp = '0;
  bit           drv_lat = 1'b0;

  // Reference: rotation/shift written as plain integer arithmetic.
  function automatic logic [W-1:0] model(input logic [W-1:0] dat, input int amt,
                                         input logic [1:0] mode);
    int unsigned         x    = dat;
    int unsigned         mask = (1 << W) - 1;
    logic signed [W-1:0] sd   = dat;
    case (mode)
      2'b00:   return W'(((x >> amt) | (x << (W - amt))) & mask);
      2'b01:   return W'(((x << amt) | (x >> (W - amt))) & mask);
      2'b10:   return W'(x >> amt);
      default: return W'(sd >>> amt);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: score the handshakes seen before the edge, then advance past the edge.
  task automatic tick();
    item_t it;
    @(negedge clk);
    acc_now = 1'b0;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid) begin
        ov_cnt++;
        checks++;
        assert (q.size() != 0) else begin
          errors++;
          $error("FAIL spurious_out: observed beat %0h expected none", out_data);
        end
        if (q.size() != 0) begin
          check("out_data", out_data, q[0].exp);
          if (out_ready) begin
            it = q.pop_front();
            pop_cnt++;
            if (it.lat) check("latency", cyc - it.acc, SW);
          end
        end
      end
      if (in_valid && in_ready) begin
        acc_now = 1'b1;
        it.exp  = drv_exp;
        it.acc  = cyc;
        it.lat  = drv_lat;
        q.push_back(it);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_rand();
    in_data = W'($urandom);
    in_amt  = SW'($urandom_range(0, W - 1));
    in_mode = 2'($urandom);
    drv_exp = model(in_data, int'(in_amt), in_mode);
    drv_lat = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] dat, input int amt, input logic [1:0] mode,
                      input logic [W-1:0] exp, input bit lat);
    bit done = 1'b0;
    in_data  = dat;
    in_amt   = SW'(amt);
    in_mode  = mode;
    drv_exp  = exp;
    drv_lat  = lat;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (acc_now) begin
        done = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL accept_timeout: observed no accept expected accept within 50 cycles");
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;

    // Single beat: ROR by 3, one-cycle output pulse, fixed latency
    out_ready = 1'b1;
    ov_cnt = 0;
    send(8'hB1, 3, 2'b00, 8'h36, 1'b1);
    repeat (6) tick();
    check("single_pulse", ov_cnt, 1);

    // Back-to-back beats in the other modes, returned in order
    send(8'hB1, 3, 2'b01, 8'h8D, 1'b1);
    send(8'hB1, 3, 2'b10, 8'h16, 1'b1);
    send(8'hB1, 3, 2'b11, 8'hF6, 1'b1);
    repeat (6) tick();
    check("b2b_empty", q.size(), 0);

    // Amount zero is identity in every mode
    for (int md = 0; md < 4; md++) send(8'h5A, 0, 2'(md), 8'h5A, 1'b1);
    drain();

    // Full pipe with downstream stalled
    out_ready = 1'b0;
    accs = 0;
    set_rand();
    in_valid = 1'b1;
    repeat (5) begin
      tick();
      if (acc_now) begin
        accs++;
        set_rand();
      end
    end
    check("stall_accepts", accs, 3);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    pop_cnt = 0;
    drain();
    check("stall_release_cnt", pop_cnt, 3);
    check("release_in_ready", in_ready, 1);

    // Bubble collapses while stalled
    out_ready = 1'b0;
    accs = 0;
    for (int i = 0; i < 5; i++) begin
      set_rand();
      in_valid = (i != 1);
      tick();
      if (acc_now) accs++;
    end
    check("bubble_accepts", accs, 3);
    check("bubble_in_ready", in_ready, 0);
    drain();

    // Reset with two beats in flight
    out_ready = 1'b1;
    set_rand();
    send(in_data, int'(in_amt), in_mode, drv_exp, 1'b0);
    set_rand();
    send(in_data, int'(in_amt), in_mode, drv_exp, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    ov_cnt = 0;
    repeat (6) tick();
    check("midrst_no_stale", ov_cnt, 0);
    send(8'hC3, 5, 2'b11, model(8'hC3, 5, 2'b11), 1'b1);
    drain();

    // ROL by a equals ROR by W-a
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] r;
      int           amt;
      r   = W'($urandom);
      amt = $urandom_range(1, W - 1);
      send(r, amt, 2'b01, model(r, W - amt, 2'b00), 1'b1);
    end
    drain();

    // Random traffic with random backpressure
    set_rand();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc_now) set_rand();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
